// File: rtl/mul_unit.sv
// ============================================================================
// Module   : mul_unit
// Purpose  : Iterative signed/unsigned DATA_WIDTH x DATA_WIDTH multiplier that
//            retires BITS_PER_CYCLE multiplier bits per cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mul_unit #(
    parameter int DATA_WIDTH     = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  clk_dcd,
    input  logic                  rst_n,
    input  logic                  ps_mul_start,
    input  logic                  ps_mul_signed,
    input  logic                  ps_mul_hi,
    input  logic                  ps_mul_abort,
    input  logic [DATA_WIDTH-1:0] xb_dtx,
    input  logic [DATA_WIDTH-1:0] xb_dty,
    output logic [DATA_WIDTH-1:0] mul_xb_dt,
    output logic                  mul_ps_busy,
    output logic                  mul_ps_done
);

    localparam int c_N  = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int c_CW = (c_N > 1) ? $clog2(c_N) : 1;
    localparam int c_PW = 2 * DATA_WIDTH;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_load;
    logic                    w_last;
    logic                    r_busy;
    logic                    r_done;
    logic [c_CW-1:0]         r_cnt;
    logic [c_PW-1:0]         r_mcand;
    logic [DATA_WIDTH-1:0]   r_mplier;
    logic [c_PW-1:0]         r_acc;
    logic                    r_neg;
    logic                    r_hi;
    logic [DATA_WIDTH-1:0]   r_res;
    logic [DATA_WIDTH-1:0]   w_magx;
    logic [DATA_WIDTH-1:0]   w_magy;
    logic [c_PW-1:0]         w_pp;
    logic [c_PW-1:0]         w_acc_nxt;
    logic [c_PW-1:0]         w_prod;

    assign w_last = (r_cnt == c_LAST);

    always_ff @(posedge clk_dcd or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_RUN);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // Abort outranks both start and RUN progress in every state.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ps_mul_start && !ps_mul_abort) begin
                    w_state_nxt = S_RUN;
                    w_load      = 1'b1;
                end
            end
            S_RUN: begin
                if (ps_mul_abort)
                    w_state_nxt = S_IDLE;
                else if (w_last)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (ps_mul_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (ps_mul_start) begin
                    w_state_nxt = S_RUN;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Magnitudes fit in DATA_WIDTH unsigned bits, including the most negative value.
    assign w_magx    = (ps_mul_signed && xb_dtx[DATA_WIDTH-1]) ? (-xb_dtx) : xb_dtx;
    assign w_magy    = (ps_mul_signed && xb_dty[DATA_WIDTH-1]) ? (-xb_dty) : xb_dty;
    assign w_pp      = r_mcand * c_PW'(r_mplier[BITS_PER_CYCLE-1:0]);
    assign w_acc_nxt = r_acc + w_pp;
    assign w_prod    = r_neg ? (-w_acc_nxt) : w_acc_nxt;

    always_ff @(posedge clk_dcd or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_hi     <= 1'b0;
            r_res    <= '0;
        end else if (w_load) begin
            r_cnt    <= '0;
            r_mcand  <= c_PW'(w_magx);
            r_mplier <= w_magy;
            r_acc    <= '0;
            r_neg    <= ps_mul_signed && (xb_dtx[DATA_WIDTH-1] ^ xb_dty[DATA_WIDTH-1]);
            r_hi     <= ps_mul_hi;
        end else if (r_state == S_RUN && !ps_mul_abort) begin
            r_cnt    <= r_cnt + c_CW'(1);
            r_mcand  <= r_mcand << BITS_PER_CYCLE;
            r_mplier <= r_mplier >> BITS_PER_CYCLE;
            r_acc    <= w_acc_nxt;
            if (w_last)
                r_res <= r_hi ? w_prod[c_PW-1:DATA_WIDTH] : w_prod[DATA_WIDTH-1:0];
        end
    end

    assign mul_xb_dt   = r_res;
    assign mul_ps_busy = r_busy;
    assign mul_ps_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mul_unit.sv
// ============================================================================
// Module   : tb_mul_unit
// Purpose  : Self-checking bench for mul_unit (1 and 4 bits per cycle builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mul_unit;

    logic        clk_dcd = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start1  = 1'b0;
    logic        start4  = 1'b0;
    logic        sgn     = 1'b0;
    logic        hi      = 1'b0;
    logic        abort   = 1'b0;
    logic [15:0] dtx     = '0;
    logic [15:0] dty     = '0;
    logic [15:0] dt1, dt4;
    logic        busy1, busy4, done1, done4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_dcd = ~clk_dcd;

    mul_unit #(.DATA_WIDTH(16), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk_dcd(clk_dcd), .rst_n(rst_n), .ps_mul_start(start1), .ps_mul_signed(sgn),
        .ps_mul_hi(hi), .ps_mul_abort(abort), .xb_dtx(dtx), .xb_dty(dty),
        .mul_xb_dt(dt1), .mul_ps_busy(busy1), .mul_ps_done(done1)
    );

    mul_unit #(.DATA_WIDTH(16), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk_dcd(clk_dcd), .rst_n(rst_n), .ps_mul_start(start4), .ps_mul_signed(sgn),
        .ps_mul_hi(hi), .ps_mul_abort(abort), .xb_dtx(dtx), .xb_dty(dty),
        .mul_xb_dt(dt4), .mul_ps_busy(busy4), .mul_ps_done(done4)
    );

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        s;
        logic        h;
        logic [15:0] e;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_dcd);
        #1;
    endtask

    // Reference: plain integer product of the interpreted operands.
    function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                            input logic s, input logic h);
        longint a, b, p;
        logic [31:0] p32;
        a   = s ? longint'($signed(x)) : longint'(x);
        b   = s ? longint'($signed(y)) : longint'(y);
        p   = a * b;
        p32 = p[31:0];
        return h ? p32[31:16] : p32[15:0];
    endfunction

    // Starts one op on both builds; checks latency (17 / 5), result and busy window.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                          input logic h, input logic [15:0] e, input string nm);
        int t1, t4, bad_busy;
        logic [15:0] r1, r4;
        t1 = -1; t4 = -1; bad_busy = 0; r1 = '0; r4 = '0;
        dtx = x; dty = y; sgn = s; hi = h; start1 = 1'b1; start4 = 1'b1;
        step();
        start1 = 1'b0; start4 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (busy1 !== (c <= 16)) bad_busy++;
            if (done1 === 1'b1 && t1 < 0) begin t1 = c; r1 = dt1; end
            if (done4 === 1'b1 && t4 < 0) begin t4 = c; r4 = dt4; end
            step();
        end
        chk({nm, " done_cycle_bpc1"}, t1, 17);
        chk({nm, " result_bpc1"}, r1, e);
        chk({nm, " done_cycle_bpc4"}, t4, 5);
        chk({nm, " result_bpc4"}, r4, e);
        chk({nm, " busy_window"}, bad_busy, 0);
    endtask

    initial begin
        vec_t tbl[9];
        int   ta, tb, extra, nodone;
        logic [15:0] ra, rb, rx, ry;
        logic rs, rh;

        tbl[0] = '{16'h0003, 16'h0005, 1'b0, 1'b0, 16'h000F};
        tbl[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h0001};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFE};
        tbl[3] = '{16'hFFFE, 16'h0003, 1'b1, 1'b0, 16'hFFFA};
        tbl[4] = '{16'hFFFE, 16'h0003, 1'b1, 1'b1, 16'hFFFF};
        tbl[5] = '{16'h8000, 16'h8000, 1'b1, 1'b1, 16'h4000};
        tbl[6] = '{16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0000};
        tbl[7] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'hFFFF};
        tbl[8] = '{16'h0007, 16'h0006, 1'b0, 1'b0, 16'h002A};

        #3;
        chk("reset dt",   dt1,   16'h0);
        chk("reset busy", busy1, 1'b0);
        chk("reset done", done1, 1'b0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++)
            run_op(tbl[i].x, tbl[i].y, tbl[i].s, tbl[i].h, tbl[i].e, $sformatf("vec%0d", i));

        // Back-to-back with start pulses during RUN that must be ignored.
        ta = -1; tb = -1; extra = 0; ra = '0; rb = '0;
        dtx = 16'h0003; dty = 16'h0005; sgn = 1'b0; hi = 1'b0; start1 = 1'b1;
        step();
        for (int c = 1; c <= 40; c++) begin
            start1 = (c == 3 || c == 8 || c == 17);
            dtx    = (c == 17) ? 16'h0007 : 16'h1234;
            dty    = (c == 17) ? 16'h0006 : 16'h4321;
            if (done1 === 1'b1) begin
                if (ta < 0) begin ta = c; ra = dt1; end
                else if (tb < 0) begin tb = c; rb = dt1; end
                else extra++;
            end
            step();
        end
        start1 = 1'b0;
        chk("b2b first_cycle",  ta, 17);
        chk("b2b first_result", ra, 16'h000F);
        chk("b2b second_cycle", tb, 34);
        chk("b2b second_result", rb, 16'h002A);
        chk("b2b extra_done", extra, 0);

        // Abort mid-RUN, then abort+start together in IDLE.
        dtx = 16'h0009; dty = 16'h0009; start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int c = 1; c < 8; c++) step();
        chk("abort busy_before", busy1, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort busy_after", busy1, 1'b0);
        start1 = 1'b1; abort = 1'b1;
        step();
        start1 = 1'b0; abort = 1'b0;
        chk("abort_start busy", busy1, 1'b0);
        nodone = 0;
        for (int c = 0; c < 20; c++) begin
            if (done1 !== 1'b0 || busy1 !== 1'b0) nodone++;
            step();
        end
        chk("abort no_done", nodone, 0);
        chk("abort dt_kept", dt1, 16'h002A);

        // Asynchronous reset in the middle of RUN.
        dtx = 16'h0003; dty = 16'h0005; start1 = 1'b1; start4 = 1'b1;
        step();
        start1 = 1'b0; start4 = 1'b0;
        for (int c = 1; c < 5; c++) step();
        rst_n = 1'b0;
        #1;
        chk("rst busy1", busy1, 1'b0);
        chk("rst dt1",   dt1,   16'h0);
        chk("rst done4", done4, 1'b0);
        chk("rst dt4",   dt4,   16'h0);
        #2 rst_n = 1'b1;
        nodone = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (done1 !== 1'b0 || done4 !== 1'b0 || busy1 !== 1'b0) nodone++;
        end
        chk("rst no_done", nodone, 0);
        run_op(16'h0003, 16'h0005, 1'b0, 1'b0, 16'h000F, "post_reset");

        for (int i = 0; i < 25; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            rs = 1'($urandom);
            rh = 1'($urandom);
            if (i < 4) rx = 16'h8000 | 16'($urandom_range(0, 1));
            run_op(rx, ry, rs, rh, ref_mul(rx, ry, rs, rh), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
